// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage divider: op encodings, FSM states
// and the default datapath width.
package riscv_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step
  import riscv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;

  // The dropped rem MSB is always zero: rem stays below 2**i after i steps.
  assign shifted  = {rem[WIDTH-2:0], dvd_msb};
  assign q_bit    = (shifted >= divisor);
  assign rem_next = q_bit ? (shifted - divisor) : shifted;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Magnitudes are divided unsigned; signs and special cases are applied at FIX.
module div_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] dvd_reg, rem_reg, dvs_reg;
  logic             neg_q_reg, neg_r_reg, is_rem_reg, dz_reg;
  logic             busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0] result_reg;

  logic             signed_op, neg_a, neg_b, b_zero, overflow, special;
  logic [WIDTH-1:0] abs_a, abs_b, rem_next, q_fix, r_fix;
  logic             q_bit;

  assign signed_op = ~op[0];
  assign neg_a     = signed_op & a[WIDTH-1];
  assign neg_b     = signed_op & b[WIDTH-1];
  assign abs_a     = neg_a ? -a : a;
  assign abs_b     = neg_b ? -b : b;
  assign b_zero    = (b == '0);
  assign overflow  = signed_op & (a == MOST_NEG) & (b == '1);
  assign special   = b_zero | overflow;

  // dvd_reg shifts the dividend out at the top and the quotient in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[WIDTH-1]),
    .divisor  (dvs_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_fix = neg_q_reg ? -dvd_reg : dvd_reg;
  assign r_fix = neg_r_reg ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = special ? FIX : CALC;
      CALC:    if (count_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
      count_reg    <= '0;
      dvd_reg      <= '0;
      rem_reg      <= '0;
      dvs_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      is_rem_reg   <= 1'b0;
      dz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          busy_reg   <= 1'b1;
          is_rem_reg <= op[1];
          dvs_reg    <= abs_b;
          count_reg  <= CW'(WIDTH);
          dz_reg     <= b_zero;
          // Special cases preload the final quotient/remainder and skip CALC.
          if (b_zero) begin
            dvd_reg   <= '1;
            rem_reg   <= a;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
          end else if (overflow) begin
            dvd_reg   <= a;
            rem_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
          end else begin
            dvd_reg   <= abs_a;
            rem_reg   <= '0;
            neg_q_reg <= neg_a ^ neg_b;
            neg_r_reg <= neg_a;
          end
        end
        CALC: begin
          dvd_reg   <= {dvd_reg[WIDTH-2:0], q_bit};
          rem_reg   <= rem_next;
          count_reg <= count_reg - CW'(1);
        end
        FIX: begin
          result_reg   <= is_rem_reg ? r_fix : q_fix;
          div_zero_reg <= dz_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign div_zero = div_zero_reg;

endmodule
